// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BURST = 2'd1,
    D_ACC   = 2'd2
  } arb_state_t;

  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned AW_DEF         = 32;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// Bundle of instruction-refill, data-access and shared memory-port signals.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned AW         = AW_DEF
);

  localparam int unsigned BW = $clog2(LINE_WORDS);

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_rvalid;
  logic [BW-1:0] i_beat;
  logic [AW-1:0] i_rdata;
  logic          i_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [AW-1:0] d_wdata;
  logic [AW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic          mem_ack;
  logic [AW-1:0] mem_rdata;

  // Arbiter side
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_rvalid, i_beat, i_rdata, i_done, d_rdata, d_done, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_rvalid, i_beat, i_rdata, i_done, d_rdata, d_done, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction-line refills and data accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned AW         = AW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.master bus
);

  localparam int unsigned BW = $clog2(LINE_WORDS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  arb_state_t    state, state_nxt;
  logic [BW-1:0] beat;
  logic [AW-1:0] i_base;
  logic          pri_i;
  logic          grant_i;
  logic          beat_ack;
  logic          last_beat;
  logic          flush_ack;

  assign grant_i   = (state == IDLE) && bus.i_req && (pri_i || !bus.d_req);
  assign beat_ack  = (state == I_BURST) && bus.mem_ack;
  assign last_beat = (beat == LAST_BEAT);
  assign flush_ack = beat_ack && !bus.i_req;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = I_BURST;
        end else if (bus.d_req) begin
          state_nxt = D_ACC;
        end
      end
      I_BURST: begin
        if (bus.mem_ack && (!bus.i_req || last_beat)) begin
          state_nxt = IDLE;
        end
      end
      D_ACC: begin
        if (bus.mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_rvalid  = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    unique case (state)
      I_BURST: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = i_base + (AW'(beat) << 2);
        bus.i_rvalid = beat_ack && bus.i_req;
        bus.i_done   = beat_ack && bus.i_req && last_beat;
      end
      D_ACC: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = bus.d_we;
        bus.mem_addr  = bus.d_addr;
        bus.mem_wdata = bus.d_wdata;
        bus.d_done    = bus.mem_ack;
      end
      default: ;
    endcase
  end

  assign bus.i_beat  = beat;
  assign bus.i_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
  assign bus.d_stall = bus.d_req && !bus.d_done;

  // Line base is captured at grant so the address stays put even if the
  // requester flushes and changes i_addr before the pending beat is acked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      i_base <= '0;
    end else if (grant_i) begin
      i_base <= bus.i_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat <= '0;
    end else if (beat_ack) begin
      beat <= (last_beat || !bus.i_req) ? '0 : beat + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pri_i <= 1'b0;
    end else if (bus.d_done) begin
      pri_i <= 1'b1;
    end else if (bus.i_done || flush_ack) begin
      pri_i <= 1'b0;
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed cycle-by-cycle vectors plus hand sequences for wait, flush and reset cases.
module tb_mem_arbiter;

  logic clk;
  logic rstn;

  mem_arbiter_if #(.LINE_WORDS(4), .AW(32)) bus ();

  mem_arbiter #(.LINE_WORDS(4), .AW(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_rv;
    logic [1:0]  e_beat;
    logic        e_done;
    logic        e_ddone;
    logic        e_stall;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  vec_t        tbl [20];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dwd, input logic ak, input logic [31:0] rd,
    input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ewd,
    input logic erv, input logic [1:0] eb, input logic edn, input logic edd, input logic est);
    vec_t r;
    r.i_req = ir;  r.i_addr = ia;  r.d_req = dr;  r.d_we = dw;
    r.d_addr = da; r.d_wdata = dwd; r.ack = ak;   r.rdata = rd;
    r.e_req = er;  r.e_we = ew;    r.e_addr = ea; r.e_wdata = ewd;
    r.e_rv = erv;  r.e_beat = eb;  r.e_done = edn; r.e_ddone = edd; r.e_stall = est;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive at the falling edge, check 2ns later, return at the next falling edge.
  task automatic apply(input vec_t v, input string tag);
    bus.i_req   = v.i_req;  bus.i_addr  = v.i_addr;
    bus.d_req   = v.d_req;  bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr; bus.d_wdata = v.d_wdata;
    bus.mem_ack = v.ack;    bus.mem_rdata = v.rdata;
    #2;
    check({tag, ".mem_req"},  32'(bus.mem_req),  32'(v.e_req));
    check({tag, ".i_rvalid"}, 32'(bus.i_rvalid), 32'(v.e_rv));
    check({tag, ".i_done"},   32'(bus.i_done),   32'(v.e_done));
    check({tag, ".d_done"},   32'(bus.d_done),   32'(v.e_ddone));
    check({tag, ".d_stall"},  32'(bus.d_stall),  32'(v.e_stall));
    if (v.e_req) begin
      check({tag, ".mem_we"},   32'(bus.mem_we), 32'(v.e_we));
      check({tag, ".mem_addr"}, bus.mem_addr,    v.e_addr);
      if (v.e_we) check({tag, ".mem_wdata"}, bus.mem_wdata, v.e_wdata);
    end else begin
      check({tag, ".mem_we_idle"}, 32'(bus.mem_we), 32'd0);
    end
    if (v.e_rv) begin
      check({tag, ".i_beat"},  32'(bus.i_beat), 32'(v.e_beat));
      check({tag, ".i_rdata"}, bus.i_rdata,     v.rdata);
    end
    if (v.e_ddone) check({tag, ".d_rdata"}, bus.d_rdata, v.rdata);
    @(negedge clk);
  endtask

  initial begin
    //          ir ia      dr dw da     dwd ak rd       er ew ea      ewd rv b  dn dd st
    tbl[0]  = mk(0, 0,      0, 0, 0,     0,  0, 0,       0, 0, 0,      0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0,      0, 0, 0,     0,  1, 'h55,    0, 0, 0,      0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 'h100,  0, 0, 0,     0,  0, 0,       0, 0, 0,      0,  0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 'h100,  0, 0, 0,     0,  1, 'hA0,    1, 0, 'h100,  0,  1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 'h100,  0, 0, 0,     0,  1, 'hA1,    1, 0, 'h104,  0,  1, 1, 0, 0, 0);
    tbl[5]  = mk(1, 'h100,  0, 0, 0,     0,  1, 'hA2,    1, 0, 'h108,  0,  1, 2, 0, 0, 0);
    tbl[6]  = mk(1, 'h100,  0, 0, 0,     0,  1, 'hA3,    1, 0, 'h10C,  0,  1, 3, 1, 0, 0);
    tbl[7]  = mk(0, 0,      0, 0, 0,     0,  0, 0,       0, 0, 0,      0,  0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 'h100,  1, 0, 'h40,  0,  0, 0,       0, 0, 0,      0,  0, 0, 0, 0, 1);
    tbl[9]  = mk(1, 'h100,  1, 0, 'h40,  0,  0, 0,       1, 0, 'h40,   0,  0, 0, 0, 0, 1);
    tbl[10] = mk(1, 'h100,  1, 0, 'h40,  0,  1, 'hD0,    1, 0, 'h40,   0,  0, 0, 0, 1, 0);
    tbl[11] = mk(1, 'h100,  1, 0, 'h80,  0,  0, 0,       0, 0, 0,      0,  0, 0, 0, 0, 1);
    tbl[12] = mk(1, 'h100,  1, 0, 'h80,  0,  1, 'hB0,    1, 0, 'h100,  0,  1, 0, 0, 0, 1);
    tbl[13] = mk(1, 'h100,  1, 0, 'h80,  0,  0, 0,       1, 0, 'h104,  0,  0, 0, 0, 0, 1);
    tbl[14] = mk(1, 'h100,  1, 0, 'h80,  0,  1, 'hB1,    1, 0, 'h104,  0,  1, 1, 0, 0, 1);
    tbl[15] = mk(1, 'h100,  1, 0, 'h80,  0,  1, 'hB2,    1, 0, 'h108,  0,  1, 2, 0, 0, 1);
    tbl[16] = mk(1, 'h100,  1, 0, 'h80,  0,  1, 'hB3,    1, 0, 'h10C,  0,  1, 3, 1, 0, 1);
    tbl[17] = mk(0, 0,      1, 0, 'h80,  0,  0, 0,       0, 0, 0,      0,  0, 0, 0, 0, 1);
    tbl[18] = mk(0, 0,      1, 0, 'h80,  0,  1, 'hD1,    1, 0, 'h80,   0,  0, 0, 0, 1, 0);
    tbl[19] = mk(0, 0,      0, 0, 0,     0,  0, 0,       0, 0, 0,      0,  0, 0, 0, 0, 0);

    // Reset state, with requests and a stray ack present.
    rstn = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 'h100; bus.d_req = 1'b1; bus.d_we = 1'b1;
    bus.d_addr = 'h0; bus.d_wdata = '0; bus.mem_ack = 1'b1; bus.mem_rdata = '0;
    #2;
    check("rst.mem_req",  32'(bus.mem_req),  32'd0);
    check("rst.mem_we",   32'(bus.mem_we),   32'd0);
    check("rst.i_rvalid", 32'(bus.i_rvalid), 32'd0);
    check("rst.i_done",   32'(bus.i_done),   32'd0);
    check("rst.d_done",   32'(bus.d_done),   32'd0);
    check("rst.d_stall",  32'(bus.d_stall),  32'd1);
    @(negedge clk);
    @(negedge clk);
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0;
    rstn = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // D write with three wait states: fields held, stall until done.
    apply(mk(0, 0, 1, 1, 'h2000, 'hDEADBEEF, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1), "dw.grant");
    for (int w = 0; w < 3; w++)
      apply(mk(0, 0, 1, 1, 'h2000, 'hDEADBEEF, 0, 0,  1, 1, 'h2000, 'hDEADBEEF,  0, 0, 0, 0, 1),
            $sformatf("dw.wait%0d", w));
    apply(mk(0, 0, 1, 1, 'h2000, 'hDEADBEEF, 1, 'h77,  1, 1, 'h2000, 'hDEADBEEF,  0, 0, 0, 1, 0), "dw.ack");

    // Flush after beat 1: pending beat 2 completes silently, then IDLE.
    apply(mk(1, 'h200, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0), "fl.grant");
    apply(mk(1, 'h200, 0, 0, 0, 0, 1, 'hC0,   1, 0, 'h200, 0,  1, 0, 0, 0, 0), "fl.b0");
    apply(mk(1, 'h200, 0, 0, 0, 0, 1, 'hC1,   1, 0, 'h204, 0,  1, 1, 0, 0, 0), "fl.b1");
    apply(mk(0, 'h200, 0, 0, 0, 0, 0, 0,      1, 0, 'h208, 0,  0, 0, 0, 0, 0), "fl.pend");
    apply(mk(0, 'h200, 0, 0, 0, 0, 1, 'hC2,   1, 0, 'h208, 0,  0, 0, 0, 0, 0), "fl.ack");
    apply(mk(0, 0,     0, 0, 0, 0, 1, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0), "fl.idle");

    // Flush cleared pri_i, so D wins the next tie; then I gets its turn.
    apply(mk(1, 'h300, 1, 0, 'h44, 0, 0, 0,    0, 0, 0, 0,      0, 0, 0, 0, 1), "tie.grant");
    apply(mk(1, 'h300, 1, 0, 'h44, 0, 0, 0,    1, 0, 'h44, 0,   0, 0, 0, 0, 1), "tie.dwait");
    apply(mk(1, 'h300, 1, 0, 'h44, 0, 1, 'hE0, 1, 0, 'h44, 0,   0, 0, 0, 1, 0), "tie.dack");
    apply(mk(1, 'h300, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0,      0, 0, 0, 0, 0), "rs.grant");
    apply(mk(1, 'h300, 0, 0, 0, 0, 1, 'hF0,    1, 0, 'h300, 0,  1, 0, 0, 0, 0), "rs.b0");
    apply(mk(1, 'h300, 0, 0, 0, 0, 1, 'hF1,    1, 0, 'h304, 0,  1, 1, 0, 0, 0), "rs.b1");
    apply(mk(1, 'h300, 0, 0, 0, 0, 0, 0,       1, 0, 'h308, 0,  0, 0, 0, 0, 0), "rs.b2wait");

    // Reset while beat 2 is outstanding.
    bus.mem_ack = 1'b1; bus.mem_rdata = 'hF2;
    rstn = 1'b0;
    #1;
    check("rs.mem_req_async", 32'(bus.mem_req),  32'd0);
    check("rs.i_done",        32'(bus.i_done),   32'd0);
    check("rs.i_rvalid",      32'(bus.i_rvalid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    apply(mk(1, 'h300, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0,      0, 0, 0, 0, 0), "rs.regrant");
    apply(mk(1, 'h300, 0, 0, 0, 0, 1, 'hF8,    1, 0, 'h300, 0,  1, 0, 0, 0, 0), "rs.restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mem_arbiter
